seg_scan_decoder: RTL and testbench

Receive-side counterpart of the clock's multiplexed 7-segment display interface. Samples the SEL/SEG scan outputs, waits for each digit's pattern to settle, and decodes it back to a 4-bit hex code per digit position. Tracks which positions have been seen and flags complete frames, bad select patterns and a stalled scan. Used as an on-chip display monitor and as the self-checking display front end in display-level benches.

---
 rtl/seg_scan_pkg.sv | 65 ++++++
 rtl/seg_settle_filter.sv | 67 ++++++
 rtl/seg_scan_decoder.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the multiplexed 7-segment display interface.
//   DIGITS         number of digit positions on the scan bus
//   GLYPH_0..F     active-high {g,f,e,d,c,b,a} patterns for the hex glyphs,
//                  shared by the transmit-side encoder and the receive-side
//                  decoder
//   settle_state_t states of the input stability filter
//   decode_glyph() maps a segment pattern to {valid, code}. An unlisted
//                  pattern returns valid = 0 and code = 0.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package seg_scan_pkg;

   localparam int DIGITS = 8;

   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   typedef enum logic {
      WAIT_CHANGE = 1'b0,
      SETTLING    = 1'b1
   } settle_state_t;

   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] result;
      result = 5'h00;
      case (seg)
         GLYPH_0: result = {1'b1, 4'h0};
         GLYPH_1: result = {1'b1, 4'h1};
         GLYPH_2: result = {1'b1, 4'h2};
         GLYPH_3: result = {1'b1, 4'h3};
         GLYPH_4: result = {1'b1, 4'h4};
         GLYPH_5: result = {1'b1, 4'h5};
         GLYPH_6: result = {1'b1, 4'h6};
         GLYPH_7: result = {1'b1, 4'h7};
         GLYPH_8: result = {1'b1, 4'h8};
         GLYPH_9: result = {1'b1, 4'h9};
         GLYPH_A: result = {1'b1, 4'hA};
         GLYPH_B: result = {1'b1, 4'hB};
         GLYPH_C: result = {1'b1, 4'hC};
         GLYPH_D: result = {1'b1, 4'hD};
         GLYPH_E: result = {1'b1, 4'hE};
         GLYPH_F: result = {1'b1, 4'hF};
         default: result = 5'h00;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/seg_settle_filter.sv
// ---------------------------------------------------------------------------
// seg_settle_filter
// Synchronizes a generic-width bus and fires a single capture strobe once
// the synchronized value has held unchanged for SETTLE_CNT cycles.
// A value that keeps holding is never captured a second time.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   din      asynchronous input bus
//   dout     synchronized bus; this is the value that capture qualifies
//   capture  one-cycle strobe: dout has settled
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module seg_settle_filter
   import seg_scan_pkg::*;
#(
   parameter int           W          = 16,
   parameter int           SETTLE_CNT = 16,
   parameter logic [W-1:0] RST_VAL    = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         capture
);

   localparam int            CW       = $clog2(SETTLE_CNT);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CNT - 1);

   logic [W-1:0]  sync_q1;
   logic [W-1:0]  sync_q2;
   logic [CW-1:0] cnt;
   logic          captured;
   settle_state_t state;

   // The change test looks at sync_q1 against sync_q2, so the count restarts
   // on the same edge that the new value lands in sync_q2.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1  <= RST_VAL;
         sync_q2  <= RST_VAL;
         cnt      <= '0;
         captured <= 1'b0;
         state    <= SETTLING;
      end else begin
         sync_q1 <= din;
         sync_q2 <= sync_q1;
         if (sync_q1 != sync_q2) begin
            cnt      <= '0;
            captured <= 1'b0;
            state    <= SETTLING;
         end else if (capture) begin
            captured <= 1'b1;
            state    <= WAIT_CHANGE;
         end else if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign capture = (cnt == CNT_LAST) && !captured;
   assign dout    = sync_q2;

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Monitors a multiplexed 7-segment scan bus and decodes every settled digit
// back to its hex code. It also tracks frame completion, bad select patterns
// and a stalled scan.
//   Clk          system clock
//   Reset_n      asynchronous active-low reset
//   SEL[7:0]     digit select pins; bit i selects position i
//   SEG[7:0]     segment pins {dp,g,f,e,d,c,b,a}
//   Digit_Code   decoded hex code per position; digit i at [4i+3:4i]
//   Digit_DP     decimal point per position; 1 = lit
//   Digit_Valid  1 = last pattern captured for the position was a hex glyph
//   Frame_Done   pulse: all positions captured since the previous frame
//   Sel_Err      pulse: a settled SEL had more than one active bit
//   Scan_Lost    level: no capture for TIMEOUT_CNT cycles
// Optional build macro SEG_SCAN_SNAPSHOT_EN adds these outputs:
//   Frame_Code   Digit_Code frozen at each Frame_Done
//   Frame_DP     Digit_DP frozen at each Frame_Done
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int   SETTLE_CNT  = 16,
   parameter int   TIMEOUT_CNT = 1_000_000,
   parameter logic SEL_ACT     = 1'b0,
   parameter logic SEG_ACT     = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [7:0]            SEL,
   input  logic [7:0]            SEG,
   output logic [DIGITS*4-1:0]   Digit_Code,
   output logic [DIGITS-1:0]     Digit_DP,
   output logic [DIGITS-1:0]     Digit_Valid,
   output logic                  Frame_Done,
   output logic                  Sel_Err,
   output logic                  Scan_Lost
`ifdef SEG_SCAN_SNAPSHOT_EN
   ,
   output logic [DIGITS*4-1:0]   Frame_Code,
   output logic [DIGITS-1:0]     Frame_DP
`endif
);

   localparam int            TW     = $clog2(TIMEOUT_CNT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CNT - 1);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CNT);

   logic [15:0]          bus_sync;
   logic                 capture;
   logic [7:0]           sel_n;
   logic [7:0]           seg_n;
   logic                 sel_none;
   logic                 sel_one;
   logic [4:0]           glyph;
   logic [DIGITS-1:0]    seen;
   logic [TW-1:0]        tmo_cnt;

   logic [DIGITS*4-1:0]  code_nx;
   logic [DIGITS-1:0]    dp_nx;
   logic [DIGITS-1:0]    valid_nx;
   logic [DIGITS-1:0]    seen_nx;
   logic                 frame_nx;
   logic                 sel_err_nx;
   logic                 lost_nx;
   logic [TW-1:0]        tmo_nx;

   seg_settle_filter #(
      .W          (16),
      .SETTLE_CNT (SETTLE_CNT),
      .RST_VAL    ({{8{~SEL_ACT}}, {8{~SEG_ACT}}})
   ) u_settle (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .din     ({SEL, SEG}),
      .dout    (bus_sync),
      .capture (capture)
   );

   // Normalize so that 1 always means "selected" or "lit".
   assign sel_n    = bus_sync[15:8] ^ {8{~SEL_ACT}};
   assign seg_n    = bus_sync[7:0]  ^ {8{~SEG_ACT}};
   assign sel_none = (sel_n == 8'h00);
   assign sel_one  = !sel_none && ((sel_n & (sel_n - 8'd1)) == 8'h00);
   assign glyph    = decode_glyph(seg_n[6:0]);

   // A capture always wins over a timeout expiring in the same cycle,
   // because the expiry only counts on cycles without a capture.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave it unassigned and infer a latch.
      code_nx    = Digit_Code;
      dp_nx      = Digit_DP;
      valid_nx   = Digit_Valid;
      seen_nx    = seen;
      frame_nx   = 1'b0;
      sel_err_nx = 1'b0;
      lost_nx    = Scan_Lost;
      tmo_nx     = tmo_cnt;
      if (capture) begin
         tmo_nx = '0;
         if (sel_one) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (sel_n[i]) begin
                  code_nx[4*i +: 4] = glyph[3:0];
                  valid_nx[i]       = glyph[4];
                  dp_nx[i]          = seg_n[7];
               end
            end
            lost_nx = 1'b0;
            seen_nx = seen | sel_n;
            if (seen_nx == '1) begin
               frame_nx = 1'b1;
               seen_nx  = '0;
            end
         end else if (!sel_none) begin
            sel_err_nx = 1'b1;
         end
      end else if (tmo_cnt != T_MAX) begin
         tmo_nx = tmo_cnt + 1'b1;
         if (tmo_cnt == T_LAST) begin
            lost_nx = 1'b1;
            seen_nx = '0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Digit_Code  <= '0;
         Digit_DP    <= '0;
         Digit_Valid <= '0;
         Frame_Done  <= 1'b0;
         Sel_Err     <= 1'b0;
         Scan_Lost   <= 1'b0;
         seen        <= '0;
         tmo_cnt     <= '0;
      end else begin
         Digit_Code  <= code_nx;
         Digit_DP    <= dp_nx;
         Digit_Valid <= valid_nx;
         Frame_Done  <= frame_nx;
         Sel_Err     <= sel_err_nx;
         Scan_Lost   <= lost_nx;
         seen        <= seen_nx;
         tmo_cnt     <= tmo_nx;
      end
   end

`ifdef SEG_SCAN_SNAPSHOT_EN
   // The snapshot loads the next-state values, so the digit that completes
   // the frame is included.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Frame_Code <= '0;
         Frame_DP   <= '0;
      end else if (frame_nx) begin
         Frame_Code <= code_nx;
         Frame_DP   <= dp_nx;
      end
   end
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
`timescale 1ns/1ps

module tb_seg_scan_decoder;

   localparam int SETTLE = 16;
   localparam int TMO    = 1000;
   localparam int LAT    = SETTLE + 2;

   localparam logic [6:0] GLYPH_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct {
      logic [31:0] pre_code;
      logic [31:0] code;
      logic [7:0]  dp;
      logic [7:0]  valid;
      logic        fd;
      logic        se;
      logic        lost;
      logic [31:0] fcode;
      logic [7:0]  fdp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  sel_pins = 8'hFF;
   logic [7:0]  seg_pins = 8'hFF;
   logic [31:0] digit_code;
   logic [7:0]  digit_dp;
   logic [7:0]  digit_valid;
   logic        frame_done;
   logic        sel_err;
   logic        scan_lost;
`ifdef SEG_SCAN_SNAPSHOT_EN
   logic [31:0] frame_code;
   logic [7:0]  frame_dp;
`endif

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state.
   logic [31:0] m_code  = '0;
   logic [7:0]  m_dp    = '0;
   logic [7:0]  m_valid = '0;
   logic [7:0]  m_seen  = '0;
   logic        m_lost  = 1'b0;
   logic [31:0] m_fcode = '0;
   logic [7:0]  m_fdp   = '0;
   exp_t        sb [$];

   always #5 clk = ~clk;

   seg_scan_decoder #(
      .SETTLE_CNT  (SETTLE),
      .TIMEOUT_CNT (TMO),
      .SEL_ACT     (1'b0),
      .SEG_ACT     (1'b0)
   ) dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .SEL         (sel_pins),
      .SEG         (seg_pins),
      .Digit_Code  (digit_code),
      .Digit_DP    (digit_dp),
      .Digit_Valid (digit_valid),
      .Frame_Done  (frame_done),
      .Sel_Err     (sel_err),
      .Scan_Lost   (scan_lost)
`ifdef SEG_SCAN_SNAPSHOT_EN
      ,
      .Frame_Code  (frame_code),
      .Frame_DP    (frame_dp)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_pins(input logic [7:0] sel, input logic [7:0] seg);
      sel_pins = sel;
      seg_pins = seg;
   endtask

   task automatic model_reset();
      m_code  = '0;
      m_dp    = '0;
      m_valid = '0;
      m_seen  = '0;
      m_lost  = 1'b0;
      m_fcode = '0;
      m_fdp   = '0;
      sb.delete();
   endtask

   // Drive pins (active-low) and push what the decoder must show once settled.
   task automatic drive(input logic [7:0] sel, input logic [7:0] seg);
      exp_t       e;
      logic [7:0] s_n;
      logic [7:0] g_n;
      logic [4:0] dec;
      int         idx;
      s_n        = ~sel;
      g_n        = ~seg;
      idx        = 0;
      e.pre_code = m_code;
      e.fd       = 1'b0;
      e.se       = 1'b0;
      if ($countones(s_n) == 1) begin
         for (int i = 0; i < 8; i++) if (s_n[i]) idx = i;
         dec = 5'h00;
         for (int k = 0; k < 16; k++) if (GLYPH_TAB[k] == g_n[6:0]) dec = {1'b1, 4'(k)};
         m_code[4*idx +: 4] = dec[3:0];
         m_valid[idx]       = dec[4];
         m_dp[idx]          = g_n[7];
         m_seen[idx]        = 1'b1;
         m_lost             = 1'b0;
         if (m_seen == 8'hFF) begin
            e.fd    = 1'b1;
            m_seen  = '0;
            m_fcode = m_code;
            m_fdp   = m_dp;
         end
      end else if (s_n != 8'h00) begin
         e.se = 1'b1;
      end
      e.code  = m_code;
      e.dp    = m_dp;
      e.valid = m_valid;
      e.lost  = m_lost;
      e.fcode = m_fcode;
      e.fdp   = m_fdp;
      sb.push_back(e);
      set_pins(sel, seg);
   endtask

   // Called on the negedge where pins were driven; returns on the negedge
   // after `hold` posedges.
   task automatic expect_capture(input string tag, input int hold);
      exp_t e;
      repeat (LAT - 1) @(negedge clk);
      check({tag, "_depth"}, sb.size(), 1);
      e = sb.pop_front();
      check({tag, "_early_code"}, digit_code, e.pre_code);
      check({tag, "_early_frame"}, frame_done, 1'b0);
      @(negedge clk);
      check({tag, "_code"}, digit_code, e.code);
      check({tag, "_valid"}, digit_valid, e.valid);
      check({tag, "_dp"}, digit_dp, e.dp);
      check({tag, "_frame"}, frame_done, e.fd);
      check({tag, "_selerr"}, sel_err, e.se);
      check({tag, "_lost"}, scan_lost, e.lost);
`ifdef SEG_SCAN_SNAPSHOT_EN
      check({tag, "_fcode"}, frame_code, e.fcode);
      check({tag, "_fdp"}, frame_dp, e.fdp);
`endif
      @(negedge clk);
      check({tag, "_frame_pulse"}, frame_done, 1'b0);
      check({tag, "_selerr_pulse"}, sel_err, 1'b0);
      repeat (hold - LAT - 1) @(negedge clk);
   endtask

   task automatic gap(input int n);
      set_pins(8'hFF, 8'hFF);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_code"}, digit_code, 32'h0);
      check({tag, "_dp"}, digit_dp, 8'h00);
      check({tag, "_valid"}, digit_valid, 8'h00);
      check({tag, "_frame"}, frame_done, 1'b0);
      check({tag, "_selerr"}, sel_err, 1'b0);
      check({tag, "_lost"}, scan_lost, 1'b0);
`ifdef SEG_SCAN_SNAPSHOT_EN
      check({tag, "_fcode"}, frame_code, 32'h0);
      check({tag, "_fdp"}, frame_dp, 8'h00);
`endif
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int order [8];
      logic [3:0] vals [8];

      // Reset state.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (30) @(negedge clk);

      // 1: scan "12345678" with blank gaps.
      for (int i = 0; i < 8; i++) begin
         drive(~(8'h01 << i), ~{1'b0, GLYPH_TAB[i+1]});
         expect_capture("scan1", 40);
         gap(4);
      end
      check("scan1_final_code", digit_code, 32'h8765_4321);
      check("scan1_final_valid", digit_valid, 8'hFF);

      // 2: 15-cycle hold is ignored; 200-cycle hold captures at cycle 18.
      set_pins(8'hFE, 8'hC0);
      repeat (15) @(negedge clk);
      gap(25);
      check("short_hold_code", digit_code, m_code);
      drive(8'hFE, 8'hC0);
      expect_capture("long_hold", 200);
      gap(4);

      // 3: multi-hot select.
      drive(8'hFC, 8'hF9);
      expect_capture("multihot", 30);
      gap(4);

      // 4: blank then dp-only on digit 3.
      drive(8'hF7, 8'hFF);
      expect_capture("blank3", 30);
      drive(8'hF7, 8'h7F);
      expect_capture("dponly3", 30);
      check("dponly3_nibble", digit_code[15:12], 4'h0);

      // 5: stall, then resume in an order that would finish early if the
      // seen mask were not cleared by the timeout.
      set_pins(8'hFF, 8'hFF);
      repeat (LAT + TMO - 1) @(negedge clk);
      check("timeout_before", scan_lost, 1'b0);
      @(negedge clk);
      check("timeout_edge", scan_lost, 1'b1);
      m_lost = 1'b1;
      m_seen = '0;
      repeat (20) @(negedge clk);
      check("timeout_held", scan_lost, 1'b1);
      order = '{1, 2, 4, 5, 6, 7, 0, 3};
      vals  = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
      for (int j = 0; j < 8; j++) begin
         drive(~(8'h01 << order[j]), ~{order[j][0], GLYPH_TAB[vals[j]]});
         expect_capture("resume", 40);
         gap(4);
      end

      // 6: reset mid-frame after five digits.
      for (int i = 0; i < 5; i++) begin
         drive(~(8'h01 << i), ~{1'b0, GLYPH_TAB[15-i]});
         expect_capture("prereset", 40);
         gap(4);
      end
      set_pins(8'hFF, 8'hFF);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      model_reset();
      repeat (3) @(negedge clk);
      drive(8'hDF, ~{1'b1, GLYPH_TAB[2]});
      rst_n = 1'b1;
      expect_capture("postreset", 40);
      gap(4);
      for (int i = 6; i < 8; i++) begin
         drive(~(8'h01 << i), ~{1'b0, GLYPH_TAB[i]});
         expect_capture("postreset", 40);
         gap(4);
      end
      for (int i = 0; i < 8; i++) begin
         drive(~(8'h01 << i), ~{1'b0, GLYPH_TAB[(i*3) % 16]});
         expect_capture("refill", 40);
         gap(4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
